seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Multiplexed scan controller for an 8-digit common-anode seven-segment display.
//  Holds a 32-bit hex value and cycles a 3-bit digit index at a programmable rate.
//  sel drives the downstream 3-to-8 active-low digit-enable decoder; seg/dp carry
//  the segment pattern for the digit currently selected.
// PARAMETERS
//  CLK_DIV   50000   clk cycles per digit slot (>=1); prescaler terminal count
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   synchronous reset, active-low
//  en          in   1   1=scan running; 0=hold sel, blank segments
//  load        in   1   single-cycle strobe: capture value/dp_mask
//  value       in   32  8 hex nibbles; nibble k = value[4k+3:4k]
//  dp_mask     in   8   decimal point request per digit, bit k = digit k, active-high
//  sel         out  3   digit index 0..7 to digit decoder
//  seg         out  7   {g,f,e,d,c,b,a}, active-low
//  dp          out  1   decimal point, active-low
//  frame_done  out  1   1-cycle pulse when sel wraps 7->0
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): sel=0, seg=7'h7F, dp=1, frame_done=0, prescaler=0,
//   shadow value/dp=0, pending=0. Reset mid-frame aborts scan; pending load discarded.
//  Prescaler: counts 0..CLK_DIV-1 while en=1; tick when count==CLK_DIV-1, then 0.
//   Width $clog2(CLK_DIV+1). CLK_DIV=1 -> tick every cycle.
//  On tick: sel <= sel+1 mod 8. Wrap 7->0 asserts frame_done on the same edge sel=0.
//  Load: load=1 captures value/dp_mask into pending regs, sets pending flag; a second
//   load before frame end overwrites pending. At wrap edge, pending copied to shadow,
//   flag cleared. Load on the wrap cycle itself: new data goes straight to shadow.
//   Display never mixes two values within one frame.
//  Outputs registered: seg/dp correspond to new sel on the same edge (0 cycles skew
//   between sel and seg). seg = hex font of shadow nibble[next sel]; dp = ~dp_mask[sel].
//  Font (active-low): 0=7'h40 1=7'h79 2=7'h24 3=7'h30 4=7'h19 5=7'h12 6=7'h02
//   7=7'h78 8=7'h00 9=7'h10 A=7'h08 b=7'h03 C=7'h46 d=7'h21 E=7'h06 F=7'h0E.
//  en=0: prescaler and sel hold; seg=7'h7F, dp=1 from next edge; frame_done=0.
//   en returning to 1 resumes at held sel and prescaler count; loads still accepted.
// CONFIGURATION
//  LEAD_ZERO_BLANK_EN defined: digits above the highest nonzero shadow nibble show
//   seg=7'h7F (dp still follows dp_mask); digit 0 always shown (value 0 -> "0").
//  Undefined: all 8 digits always shown, leading zeros included.
// STRUCTURE
//  Shared package seg_scan_pkg: DIGITS=8, SEL_W=3, SEG_BLANK=7'h7F, 16-entry font
//   constants, seg bit-order definition.
//  Sub-module hex_to_seg7 (4-bit nibble -> 7-bit active-low pattern, combinational);
//   top holds prescaler, sel counter, pending/shadow regs, blanking, output regs.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with en=1 -> sel=0, seg=7'h7F, dp=1, frame_done=0.
//  2 CLK_DIV=4, load value=32'h76543210, dp_mask=0 -> after first wrap sel steps every
//    4 cycles; seg at sel=k equals font(k); frame_done pulses every 32 cycles.
//  3 Mid-frame load 32'hFFFFFFFF at sel=3 -> digits 4..7 of current frame keep old
//    value; seg=7'h0E on every digit from next sel=0.
//  4 load asserted exactly on wrap cycle with 32'h0000ABCD -> frame starting at that
//    edge shows D,C,B,A on sel 0..3; no mixed frame.
//  5 en=0 for 20 cycles at sel=5 -> sel stays 5, seg=7'h7F, dp=1, no frame_done;
//    en=1 -> resumes from sel=5 with preserved prescaler count.
//  6 LEAD_ZERO_BLANK_EN, value=32'h00000120, dp_mask=8'h80 -> sel 0..2 show 0,2,1;
//    sel 3..7 seg=7'h7F; dp=0 only at sel=7. Without macro sel 3..7 show 7'h40.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan controller: digit geometry,
// segment bit order {g,f,e,d,c,b,a} (active-low) and the hex font.
package seg_scan_pkg;

    localparam int unsigned DIGITS = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned VAL_W  = DIGITS * NIB_W;

    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg7_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Entry n is the active-low pattern for hex digit n (index 15 is the MSB slice)
    localparam logic [15:0][SEG_W-1:0] FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
    import seg_scan_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    output logic [SEG_W-1:0] seg_c_o
);

    seg7_t pattern;

    assign pattern = seg7_t'(FONT[nibble_i]);
    assign seg_c_o = pattern;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with frame-coherent loads.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [SEL_W-1:0] sel,
    output logic [SEG_W-1:0] seg,
    output logic             dp,
    output logic             frame_done
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [VAL_W-1:0]  pend_val_q, pend_val_d, shad_val_q, shad_val_d;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
    logic              pend_q, pend_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              fd_q, fd_d;

    logic              tick;
    logic              wrap;
    logic              blank;
    logic [NIB_W-1:0]  nibble;
    logic [SEG_W-1:0]  font_seg;

    hex_to_seg7 u_font (
        .nibble_i (nibble),
        .seg_c_o  (font_seg)
    );

    // Segment data is looked up from next-state sel/shadow so seg never lags sel
    assign nibble = shad_val_d[{sel_d, 2'b00} +: NIB_W];

`ifdef LEAD_ZERO_BLANK_EN
    logic [SEL_W-1:0] lead_hi;

    always_comb begin
        lead_hi = '0;
        for (int k = 1; k < DIGITS; k++) begin
            if (shad_val_d[k*NIB_W +: NIB_W] != '0) lead_hi = SEL_W'(k);
        end
        blank = (sel_d > lead_hi);
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_d     = pend_q;
        shad_val_d = shad_val_q;
        shad_dp_d  = shad_dp_q;
        seg_d      = SEG_BLANK;
        dp_d       = 1'b1;
        fd_d       = 1'b0;

        tick = en && (cnt_q == CNT_W'(CLK_DIV - 1));
        wrap = tick && (sel_q == SEL_W'(DIGITS - 1));

        if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        if (tick) sel_d = sel_q + SEL_W'(1);

        // Shadow only changes at a frame boundary; a load on that edge bypasses pending
        if (wrap) begin
            pend_d = 1'b0;
            if (load) begin
                shad_val_d = value;
                shad_dp_d  = dp_mask;
            end else if (pend_q) begin
                shad_val_d = pend_val_q;
                shad_dp_d  = pend_dp_q;
            end
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_mask;
            pend_d     = 1'b1;
        end

        if (en) begin
            seg_d = blank ? SEG_BLANK : font_seg;
            dp_d  = ~shad_dp_d[sel_d];
            fd_d  = wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sel_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_q     <= 1'b0;
            shad_val_q <= '0;
            shad_dp_q  <= '0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            fd_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            shad_val_q <= shad_val_d;
            shad_dp_q  <= shad_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            fd_q       <= fd_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (CLK_DIV=4) against a behavioural frame model.
module tb_seg_scan_ctrl;

    localparam int unsigned CLK_DIV = 4;
`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, load;
    logic [31:0] value;
    logic [7:0]  dp_mask;
    logic [2:0]  sel;
    logic [6:0]  seg;
    logic        dp, frame_done;

    logic [6:0] font_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_mask    (dp_mask),
        .sel        (sel),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // Reference model: what the display should show after each edge
    int          m_cnt = 0, m_sel = 0;
    logic [31:0] m_shv = '0, m_pv = '0;
    logic [7:0]  m_shd = '0, m_pd = '0;
    bit          m_pend = 1'b0;
    logic [6:0]  m_seg = 7'h7F;
    bit          m_dp = 1'b1, m_fd = 1'b0;

    function automatic logic [6:0] disp(input logic [31:0] v, input int k);
        int hi = 0;
        for (int i = 0; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) hi = i;
        if (LZB && k > hi) return 7'h7F;
        return font_t[int'((v >> (4 * k)) & 32'hF)];
    endfunction

    always @(posedge clk) begin : model
        bit          tk, wr;
        int          ns;
        logic [31:0] nv;
        logic [7:0]  nd;
        if (!rst_n) begin
            m_cnt <= 0; m_sel <= 0; m_shv <= '0; m_shd <= '0; m_pv <= '0; m_pd <= '0;
            m_pend <= 1'b0; m_seg <= 7'h7F; m_dp <= 1'b1; m_fd <= 1'b0;
        end else begin
            tk = en && (m_cnt == CLK_DIV - 1);
            wr = tk && (m_sel == 7);
            nv = m_shv;
            nd = m_shd;
            if (wr) begin
                if (load) begin nv = value; nd = dp_mask; end
                else if (m_pend) begin nv = m_pv; nd = m_pd; end
                m_pend <= 1'b0;
            end else if (load) begin
                m_pv <= value; m_pd <= dp_mask; m_pend <= 1'b1;
            end
            m_shv <= nv;
            m_shd <= nd;
            if (en) begin
                ns = tk ? (m_sel + 1) % 8 : m_sel;
                m_cnt <= tk ? 0 : m_cnt + 1;
                m_sel <= ns;
                m_seg <= disp(nv, ns);
                m_dp  <= ~nd[ns];
                m_fd  <= wr;
            end else begin
                m_seg <= 7'h7F; m_dp <= 1'b1; m_fd <= 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; load = 1'b0; value = '0; dp_mask = '0;
        repeat (3) cyc();
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d exp 0", sel); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h exp 7f", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b exp 1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b exp 0", frame_done); end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int n = 0, last = -1;
        value = 32'h76543210; dp_mask = 8'h00; load = 1'b1;
        cyc();
        load = 1'b0;
        while (frame_done !== 1'b1 && n < 200) begin cyc(); n++; end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL scan_first_wrap: got no frame_done in %0d cycles", n); end
        last = 0;
        for (int c = 1; c <= 64; c++) begin
            cyc();
            checks++;
            if ({sel, seg, dp, frame_done} !== {3'(m_sel), m_seg, m_dp, m_fd}) begin
                errors++;
                $display("FAIL scan_model: got sel/seg/dp/fd %0d/%h/%b/%b exp %0d/%h/%b/%b",
                         sel, seg, dp, frame_done, m_sel, m_seg, m_dp, m_fd);
            end
            checks++;
            if (seg !== font_t[sel]) begin errors++; $display("FAIL scan_font: sel %0d got %h exp %h", sel, seg, font_t[sel]); end
            if (frame_done === 1'b1) begin
                checks++;
                if (c - last != 32) begin errors++; $display("FAIL scan_frame_period: got %0d exp 32", c - last); end
                last = c;
            end
        end
    endtask

    task automatic test_midframe_load();
        int n = 0;
        while (sel !== 3'd3 && n < 100) begin cyc(); n++; end
        checks++; if (sel !== 3'd3) begin errors++; $display("FAIL mid_wait_sel3: got %0d exp 3", sel); end
        value = 32'hFFFFFFFF; load = 1'b1;
        cyc();
        load = 1'b0; n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            checks++;
            if (seg !== font_t[sel]) begin errors++; $display("FAIL mid_old_frame: sel %0d got %h exp %h", sel, seg, font_t[sel]); end
            cyc(); n++;
        end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL mid_wrap: got no frame_done"); end
        for (int c = 0; c < 32; c++) begin
            checks++;
            if (seg !== 7'h0E) begin errors++; $display("FAIL mid_new_frame: sel %0d got %h exp 0e", sel, seg); end
            cyc();
        end
    endtask

    task automatic test_wrap_load();
        logic [6:0] exp_s;
        int n = 0;
        while (!(m_sel == 7 && m_cnt == CLK_DIV - 1) && n < 100) begin cyc(); n++; end
        value = 32'h0000ABCD; dp_mask = 8'h00; load = 1'b1;
        cyc();
        load = 1'b0;
        checks++; if (frame_done !== 1'b1 || sel !== 3'd0) begin errors++; $display("FAIL wrap_load_edge: got fd %b sel %0d exp 1 0", frame_done, sel); end
        for (int c = 0; c < 32; c++) begin
            case (sel)
                3'd0: exp_s = 7'h21;
                3'd1: exp_s = 7'h46;
                3'd2: exp_s = 7'h03;
                3'd3: exp_s = 7'h08;
                default: exp_s = LZB ? 7'h7F : 7'h40;
            endcase
            checks++;
            if (seg !== exp_s) begin errors++; $display("FAIL wrap_load_frame: sel %0d got %h exp %h", sel, seg, exp_s); end
            cyc();
        end
    endtask

    task automatic test_enable_hold();
        int n = 0;
        while (sel !== 3'd5 && n < 100) begin cyc(); n++; end
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            checks++;
            if (sel !== 3'd5 || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL hold: got sel/seg/dp/fd %0d/%h/%b/%b exp 5/7f/1/0", sel, seg, dp, frame_done);
            end
        end
        en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cyc();
            checks++;
            if ({sel, seg, dp, frame_done} !== {3'(m_sel), m_seg, m_dp, m_fd}) begin
                errors++;
                $display("FAIL resume_model: got sel/seg/dp/fd %0d/%h/%b/%b exp %0d/%h/%b/%b",
                         sel, seg, dp, frame_done, m_sel, m_seg, m_dp, m_fd);
            end
        end
    endtask

    task automatic test_lead_zero();
        logic [6:0] exp_s;
        int n = 0;
        value = 32'h00000120; dp_mask = 8'h80; load = 1'b1;
        cyc();
        load = 1'b0;
        while (frame_done !== 1'b1 && n < 100) begin cyc(); n++; end
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL lz_wrap: got no frame_done"); end
        for (int c = 0; c < 32; c++) begin
            case (sel)
                3'd0: exp_s = 7'h40;
                3'd1: exp_s = 7'h24;
                3'd2: exp_s = 7'h79;
                default: exp_s = LZB ? 7'h7F : 7'h40;
            endcase
            checks++;
            if (seg !== exp_s || dp !== (sel != 3'd7)) begin
                errors++;
                $display("FAIL lead_zero: sel %0d got seg %h dp %b exp %h %b", sel, seg, dp, exp_s, sel != 3'd7);
            end
            cyc();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n   = ($urandom % 150) != 0;
            en      = ($urandom % 8) != 0;
            load    = ($urandom % 12) == 0;
            value   = $urandom;
            dp_mask = 8'($urandom);
            cyc();
            checks++;
            if ({sel, seg, dp, frame_done} !== {3'(m_sel), m_seg, m_dp, m_fd}) begin
                errors++;
                $display("FAIL random_model: cyc %0d got sel/seg/dp/fd %0d/%h/%b/%b exp %0d/%h/%b/%b",
                         c, sel, seg, dp, frame_done, m_sel, m_seg, m_dp, m_fd);
            end
        end
        rst_n = 1'b1; load = 1'b0; en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe_load();
        test_wrap_load();
        test_enable_hold();
        test_lead_zero();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
